// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared types and helpers for the round-robin bus multiplexer
package mux_pkg;

    typedef enum logic {ARB_RR = 1'b0, ARB_FIXED = 1'b1} arb_mode_t;

    localparam int MAX_N = 16;
    localparam int IDXW  = 4;

    function automatic logic [IDXW-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) begin
                idx = IDXW'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_bus_mux_arbiter.sv
// rtl/rr_bus_mux_arbiter.sv - combinational round-robin / fixed-priority one-hot arbiter
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  arb_mode_t       mode,
    output logic [N-1:0]    gnt
);

    logic [SELW-1:0] base;
    logic [2*N-1:0]  rot;
    logic [2*N-1:0]  pick_wide;
    logic [N-1:0]    pick;
    logic            found;

    always_comb begin
        base      = (mode == ARB_FIXED) ? '0 : ptr;
        // Rotating the doubled vector puts the channel at the pointer in bit 0.
        rot       = {req, req} >> base;
        pick      = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (rot[i] && !found) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
        pick_wide = {{N{1'b0}}, pick} << base;
        gnt       = pick_wide[N-1:0] | pick_wide[2*N-1:N];
    end

endmodule

// File: rtl/rr_bus_mux.sv
// rtl/rr_bus_mux.sv - registered N-channel bus multiplexer with round-robin, fixed or forced selection
module rr_bus_mux
    import mux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [N*WIDTH-1:0] In_data,
    input  logic [N-1:0]       In_valid,
    output logic [N-1:0]       In_ready,
    input  logic               Mode,
    input  logic               Force_en,
    input  logic [SELW-1:0]    Force_sel,
    output logic [WIDTH-1:0]   Out_data,
    output logic               Out_valid,
    input  logic               Out_ready,
    output logic [N-1:0]       Grant
);

    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [N-1:0]     arb_gnt;
    logic [N-1:0]     force_gnt;
    logic [WIDTH-1:0] sel_data;
    logic [SELW-1:0]  gnt_idx;
    logic             load;
    logic             accept;

    rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
        .req  (In_valid),
        .ptr  (ptr_q),
        .mode (arb_mode_t'(Mode)),
        .gnt  (arb_gnt)
    );

    always_comb begin
        force_gnt = '0;
        for (int i = 0; i < N; i++) begin
            force_gnt[i] = (Force_sel == SELW'(i)) && In_valid[i];
        end
        Grant    = Force_en ? force_gnt : arb_gnt;
        load     = !out_valid_q || Out_ready;
        // In_ready is held low during reset so nothing looks accepted while the block is cleared.
        In_ready = Grant & {N{load && Reset}};
        accept   = (|Grant) && load;

        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            sel_data = sel_data | (In_data[i*WIDTH +: WIDTH] & {WIDTH{Grant[i]}});
        end
        gnt_idx = SELW'(onehot_to_idx(MAX_N'(Grant)));
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_data_d  = sel_data;
            out_valid_d = 1'b1;
            // Only round-robin advances the pointer; forced and fixed selections leave it alone.
            if (!Force_en && (arb_mode_t'(Mode) == ARB_RR)) begin
                ptr_d = (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + SELW'(1);
            end
        end else if (Out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign Out_data  = out_data_q;
    assign Out_valid = out_valid_q;

endmodule
